// File: rtl/cpc_ram_cfg_capture_if.sv
// Z80 expansion-connector signals observed by the RAM configuration capture stage.
// The bench drives the bus through the master modport; the capture stage only listens.
interface cpc_ram_cfg_capture_if;
   logic       IOREQ_B;
   logic       WR_B;
   logic       M1_B;
   logic       A15;
   logic       A8;
   logic [7:0] D;

   modport master (output IOREQ_B, WR_B, M1_B, A15, A8, D);
   modport slave  (input  IOREQ_B, WR_B, M1_B, A15, A8, D);
endinterface

// File: rtl/cpc_ram_cfg_capture.sv
// Capture stage for the 1 MB RAM expansion config port (&7Fxx, D7:D6=11), with registered outputs.
// Define CPCRAM_GLITCH_FILTER_EN to require STABLE_CYCLES identical samples before a commit.
module cpc_ram_cfg_capture #(
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic                        CLK,
   input  logic                        RESET_B,
   cpc_ram_cfg_capture_if.slave        bus,
   output logic [2:0]                  cfg_block,
   output logic [2:0]                  cfg_adrhi,
   output logic                        cfg_a8,
   output logic                        cfg_wr,
   output logic                        busy,
   output logic [7:0]                  wr_count
);

`ifdef CPCRAM_GLITCH_FILTER_EN
   localparam int unsigned STABLE_EFF = STABLE_CYCLES;
`else
   // Without the filter every qualifying sample commits; the parameter only keeps the interface stable.
   localparam int unsigned STABLE_EFF = (STABLE_CYCLES > 0) ? 1 : 1;
`endif

   typedef enum logic [1:0] {IDLE, QUAL, WAIT_END} state_t;

   logic       r_ioreq_b, r_wr_b, r_m1_b, r_a15, r_a8;
   logic [7:0] r_d;
   logic       w_q;
   logic [6:0] w_cap;
   logic       w_commit;
   state_t     r_state, w_state_nxt;
`ifdef CPCRAM_GLITCH_FILTER_EN
   logic [2:0] r_cnt, w_cnt_nxt;
   logic [6:0] r_latch, w_latch_nxt;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         r_ioreq_b <= 1'b1;
         r_wr_b    <= 1'b1;
         r_m1_b    <= 1'b1;
         r_a15     <= 1'b0;
         r_a8      <= 1'b0;
         r_d       <= 8'h00;
      end else begin
         r_ioreq_b <= bus.IOREQ_B;
         r_wr_b    <= bus.WR_B;
         r_m1_b    <= bus.M1_B;
         r_a15     <= bus.A15;
         r_a8      <= bus.A8;
         r_d       <= bus.D;
      end
   end

   assign w_q   = !r_ioreq_b && !r_wr_b && r_m1_b && !r_a15 && (r_d[7:6] == 2'b11);
   assign w_cap = {r_a8, r_d[5:0]};

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
`ifdef CPCRAM_GLITCH_FILTER_EN
      w_cnt_nxt   = r_cnt;
      w_latch_nxt = r_latch;
`endif
      case (r_state)
         IDLE: begin
            if (w_q) begin
               if (STABLE_EFF == 1) begin
                  w_commit    = 1'b1;
                  w_state_nxt = WAIT_END;
               end
`ifdef CPCRAM_GLITCH_FILTER_EN
               else begin
                  w_latch_nxt = w_cap;
                  w_cnt_nxt   = 3'd1;
                  w_state_nxt = QUAL;
               end
`endif
            end
         end
`ifdef CPCRAM_GLITCH_FILTER_EN
         QUAL: begin
            if (!w_q) begin
               w_state_nxt = IDLE;
            end else if (w_cap != r_latch) begin
               w_latch_nxt = w_cap;
               w_cnt_nxt   = 3'd1;
            end else if (r_cnt == 3'(STABLE_CYCLES - 1)) begin
               w_commit    = 1'b1;
               w_state_nxt = WAIT_END;
            end else begin
               w_cnt_nxt   = r_cnt + 3'd1;
            end
         end
`endif
         WAIT_END: begin
            // One commit per bus cycle: wait for the strobe to end before re-arming.
            if (r_ioreq_b || r_wr_b) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         r_state   <= IDLE;
         busy      <= 1'b0;
         cfg_wr    <= 1'b0;
         cfg_block <= 3'd0;
         cfg_adrhi <= 3'd0;
         cfg_a8    <= 1'b0;
         wr_count  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt != IDLE);
         cfg_wr  <= w_commit;
         if (w_commit) begin
            cfg_block <= w_cap[2:0];
            cfg_adrhi <= w_cap[5:3];
            cfg_a8    <= w_cap[6];
            wr_count  <= wr_count + 8'd1;
         end
      end
   end

`ifdef CPCRAM_GLITCH_FILTER_EN
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         r_cnt   <= 3'd0;
         r_latch <= 7'd0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_latch <= w_latch_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_cpc_ram_cfg_capture.sv
// Self-checking bench for cpc_ram_cfg_capture: run-length model of the pin stream plus literal checks.
// Works with or without CPCRAM_GLITCH_FILTER_EN; literal expectations follow the effective stable count.
module tb_cpc_ram_cfg_capture;
   localparam int STABLE = 2;
`ifdef CPCRAM_GLITCH_FILTER_EN
   localparam int EFF = STABLE;
`else
   localparam int EFF = 1;
`endif

   logic       CLK = 1'b0;
   logic       RESET_B;
   logic [2:0] cfg_block, cfg_adrhi;
   logic       cfg_a8, cfg_wr, busy;
   logic [7:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;
   int obs_pulses = 0;
   int obs_busy   = 0;

   cpc_ram_cfg_capture_if bus ();

   cpc_ram_cfg_capture #(.STABLE_CYCLES(STABLE)) dut (
      .CLK(CLK), .RESET_B(RESET_B), .bus(bus),
      .cfg_block(cfg_block), .cfg_adrhi(cfg_adrhi), .cfg_a8(cfg_a8),
      .cfg_wr(cfg_wr), .busy(busy), .wr_count(wr_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a commit happens once a bus cycle shows EFF consecutive qualifying samples with equal capture data.
   logic       p_ioreq, p_wr, p_m1, p_a15, p_a8;
   logic [7:0] p_d;
   int         run;
   logic [6:0] run_cap;
   logic       lock;
   logic [2:0] e_block, e_adrhi;
   logic       e_a8, e_wr, e_busy;
   logic [7:0] e_count;

   always @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         {p_ioreq, p_wr, p_m1} = 3'b111;
         {p_a15, p_a8, p_d}    = '0;
         run = 0; run_cap = '0; lock = 1'b0;
         e_block = '0; e_adrhi = '0; e_a8 = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_count = '0;
      end else begin
         logic       q;
         logic [6:0] cap;
         q   = !p_ioreq && !p_wr && p_m1 && !p_a15 && (p_d[7:6] == 2'b11);
         cap = {p_a8, p_d[5:0]};
         e_wr = 1'b0;
         if (lock) begin
            if (p_ioreq || p_wr) lock = 1'b0;
         end else if (!q) begin
            run = 0;
         end else begin
            if (run == 0 || cap != run_cap) begin
               run = 1;
               run_cap = cap;
            end else begin
               run++;
            end
            if (run == EFF) begin
               e_block = cap[2:0];
               e_adrhi = cap[5:3];
               e_a8    = cap[6];
               e_count = e_count + 8'd1;
               e_wr    = 1'b1;
               lock    = 1'b1;
               run     = 0;
            end
         end
         e_busy = lock || (run > 0);
         p_ioreq = bus.IOREQ_B; p_wr = bus.WR_B; p_m1 = bus.M1_B;
         p_a15 = bus.A15; p_a8 = bus.A8; p_d = bus.D;
      end
   end

   always @(negedge CLK) begin
      check("cfg_block", 32'(cfg_block), 32'(e_block));
      check("cfg_adrhi", 32'(cfg_adrhi), 32'(e_adrhi));
      check("cfg_a8",    32'(cfg_a8),    32'(e_a8));
      check("cfg_wr",    32'(cfg_wr),    32'(e_wr));
      check("busy",      32'(busy),      32'(e_busy));
      check("wr_count",  32'(wr_count),  32'(e_count));
      if (cfg_wr) obs_pulses++;
      if (busy)   obs_busy++;
   end

   task automatic bus_idle();
      bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.M1_B = 1'b1;
      bus.A15 = 1'b0; bus.A8 = 1'b0; bus.D = 8'h00;
   endtask

   // Strobes low for n_low edges; D = d0 for the first n_d0 of them, then d1.
   task automatic io_write(input logic a15, input logic a8, input logic m1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int n_low, input int n_d0);
      for (int i = 0; i < n_low; i++) begin
         @(negedge CLK);
         bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.M1_B = m1;
         bus.A15 = a15; bus.A8 = a8; bus.D = (i < n_d0) ? d0 : d1;
      end
      @(negedge CLK);
      bus_idle();
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      int p0;
      logic [7:0] c0;
      RESET_B = 1'b0;
      bus_idle();
      repeat (3) @(negedge CLK);
      #1;
      check("reset_cfg_block", 32'(cfg_block), 0);
      check("reset_wr_count",  32'(wr_count),  0);
      check("reset_busy",      32'(busy),      0);
      @(negedge CLK);
      RESET_B = 1'b1;
      repeat (2) @(negedge CLK);

      // OUT &7F00,&C5
      p0 = obs_pulses;
      io_write(1'b0, 1'b1, 1'b1, 8'hC5, 8'hC5, 3, 3);
      check("t1_block", 32'(cfg_block), 5);
      check("t1_adrhi", 32'(cfg_adrhi), 0);
      check("t1_a8",    32'(cfg_a8),    1);
      check("t1_count", 32'(wr_count),  1);
      check("t1_pulses", 32'(obs_pulses - p0), 1);

      // One-cycle strobe glitch carrying D=&FF
      p0 = obs_busy;
      io_write(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1, 1);
      check("t2_count", 32'(wr_count),  (EFF > 1) ? 1 : 2);
      check("t2_block", 32'(cfg_block), (EFF > 1) ? 5 : 7);
      check("t2_a8",    32'(cfg_a8),    (EFF > 1) ? 1 : 0);
      check("t2_busy_cycles", 32'(obs_busy - p0), 1);

      // Data settles from &C1 to &C2 inside one strobe
      p0 = obs_pulses;
      c0 = wr_count;
      io_write(1'b0, 1'b0, 1'b1, 8'hC1, 8'hC2, 4, 1);
      check("t3_block",  32'(cfg_block), (EFF > 1) ? 2 : 1);
      check("t3_pulses", 32'(obs_pulses - p0), 1);
      check("t3_count",  32'(wr_count), 32'(8'(c0 + 8'd1)));

      // Non-qualifying writes: wrong D7:D6, A15 high, M1 low
      p0 = obs_pulses;
      c0 = wr_count;
      io_write(1'b0, 1'b1, 1'b1, 8'h85, 8'h85, 3, 3);
      io_write(1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3, 3, 3);
      io_write(1'b0, 1'b1, 1'b0, 8'hC3, 8'hC3, 3, 3);
      check("t4_pulses", 32'(obs_pulses - p0), 0);
      check("t4_count",  32'(wr_count), 32'(c0));
      check("t4_block",  32'(cfg_block), (EFF > 1) ? 2 : 1);

      // 256 valid writes wrap the counter back to its start value
      p0 = obs_pulses;
      c0 = wr_count;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         io_write(1'b0, iv[0], 1'b1, 8'hC0 | {2'b00, iv[5:0]}, 8'hC0 | {2'b00, iv[5:0]}, 2, 2);
      end
      check("t5_pulses", 32'(obs_pulses - p0), 256);
      check("t5_count",  32'(wr_count), 32'(c0));
      check("t5_block",  32'(cfg_block), 7);
      check("t5_adrhi",  32'(cfg_adrhi), 7);
      check("t5_a8",     32'(cfg_a8), 1);

      // Reset while a qualifying write is in progress
      @(negedge CLK);
      bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.D = 8'hC7;
      repeat (2) @(negedge CLK);
      #2 RESET_B = 1'b0;
      #1;
      check("t6_rst_block", 32'(cfg_block), 0);
      check("t6_rst_adrhi", 32'(cfg_adrhi), 0);
      check("t6_rst_a8",    32'(cfg_a8),    0);
      check("t6_rst_busy",  32'(busy),      0);
      check("t6_rst_count", 32'(wr_count),  0);
      @(negedge CLK);
      bus_idle();
      @(negedge CLK);
      RESET_B = 1'b1;
      repeat (2) @(negedge CLK);
      io_write(1'b0, 1'b0, 1'b1, 8'hDB, 8'hDB, 3, 3);
      check("t6_block", 32'(cfg_block), 3);
      check("t6_adrhi", 32'(cfg_adrhi), 3);
      check("t6_count", 32'(wr_count),  1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
